font_rom_arbiter: RTL
=====================

# font_rom_arbiter

Shares one synchronous font ROM between several text/dialog requesters, so game screens can drive multiple text layers from a single ROM instead of one ROM per layer. Each requester presents an 11-bit glyph-line address: char code in [10:4], line in [3:0]. The arbiter grants one requester per cycle and drives the ROM address from a register. It returns the 8-bit pixel row with a valid strobe, routed to the requester that issued the fetch. It sits between the text generators and `font_rom` inside the game content layer.

## Interface
- `N_REQ`, 2: number of requesters, 2..4.
- `ADDR_W`, 11: ROM address width.
- `DATA_W`, 8: ROM data width (one glyph line).
- `ROM_LAT`, 1: ROM read latency in cycles, registered address to data, 1..2.

- `clk` in 1: system clock, the VGA pixel clock domain.
- `rst` in 1: reset, asynchronous, active-low.
- `req` in N_REQ: per-requester fetch request. Held with a stable address until granted.
- `req_addr` in N_REQ*ADDR_W: packed addresses. Requester i uses bits [i*ADDR_W +: ADDR_W].
- `gnt` out N_REQ: combinational one-hot grant. The request is accepted at the rising edge ending the cycle in which `gnt[i]` is high.
- `rvalid` out N_REQ: one-hot, one-cycle strobe marking the returned data for requester i.
- `rdata` out DATA_W: returned glyph line. Meaningful only while some `rvalid` bit is high.
- `rom_addr` out ADDR_W: registered ROM address.
- `rom_data` in DATA_W: ROM output.
- `busy` out 1: high while any fetch is in flight in the return pipeline.

## Operation
- **Arbitration:** round-robin pointer `ptr`, width clog2(N_REQ).
  - The winner is the first i with `req[i]`, scanning ptr, ptr+1, … modulo N_REQ.
  - `gnt` is all-zero when `req` is zero.
  - Exactly one `gnt` bit is high whenever any `req` bit is high. The arbiter never stalls; one fetch is issued per cycle.
- **Pointer update:** on each accepted grant to requester w, `ptr` becomes (w+1) mod N_REQ. With no request, `ptr` holds.
- **Issue:** on accept, `rom_addr` loads the winner's address. A tag pipeline of depth ROM_LAT+1 shifts a valid bit and the winner's id.
  - With no accept, `rom_addr` holds its value and a zero valid bit enters the pipe.
- **Return:** when the tag pipe output is valid with id k, `rvalid[k]`=1 for one cycle and `rdata` is taken from `rom_data`.
  - `rdata` is registered together with `rvalid`.
  - `rdata` holds its last value when `rvalid`=0.
- **Busy:** `busy` = OR of all valid bits in the tag pipe.
- **Protocol checks:** a requester that drops `req` before `gnt` loses nothing; nothing was issued. Changing `req_addr` while `req` is high and not yet granted is a protocol violation, flagged by a simulation-only assertion.

## Timing
- **Reset values:** `rom_addr`=0, `ptr`=0, tag pipe all invalid, `rvalid`=0, `rdata`=0, `busy`=0. `gnt` follows `req` combinationally, even during reset.
- **Latency:** accept at edge E → `rom_addr` valid after E → `rom_data` valid after E+ROM_LAT → `rvalid`/`rdata` valid in the cycle after edge E+ROM_LAT+1.
  - For ROM_LAT=1, data is returned 2 cycles after grant.
- **Throughput:** one fetch per cycle, fully pipelined. Back-to-back grants to the same requester are allowed when only it requests.
- **Simultaneous requests:** all requesters high continuously → grants rotate 0,1,…,N_REQ-1,0,… One grant per cycle, and starvation is bounded to N_REQ-1 cycles.
- **Reset mid-operation:** asserting `rst` clears all in-flight tags. No `rvalid` is emitted for fetches issued before reset.

## Configuration
- `FONT_ARB_FIXED_PRIO_EN` defined: round-robin is removed and `ptr` is not implemented.
  - The lowest-index requesting port always wins. Requester 0 is meant for the foreground dialog layer.
  - Lower-priority requesters may starve.
- `FONT_ARB_FIXED_PRIO_EN` undefined: round-robin behaves as described above.

## Test plan
- **Reset:** hold `rst`=0 with `req`=2'b11 → `rvalid`=0, `busy`=0, `rom_addr`=0. On release, `gnt`=2'b01.
- **Single requester, ROM_LAT=1:** `req`=2'b01, addr 0x412 for one grant → `rom_addr`=0x412 next cycle. `rvalid`=2'b01 two cycles after grant, with `rdata` equal to the ROM model's content at 0x412.
- **Both requesting continuously:** addrs 0x100 and 0x200 → grants alternate 01,10,01,10. `rvalid` alternates with the same pattern 2 cycles later, and `rdata` alternates between the 0x100 and 0x200 contents.
- **Pointer fairness:** grant req0; next cycle only req1 → req1 granted. The following cycle both request → req0 granted (`ptr`=0 after req1's grant).
- **Reset mid-flight:** grant at cycle T, assert `rst` at T+1 → no `rvalid` at T+2; `busy`=0.
- **FONT_ARB_FIXED_PRIO_EN build:** both requesting continuously for 8 cycles → `gnt`=2'b01 every cycle and `rvalid[1]` never asserts.

Source files
------------

// File: rtl/font_rom_arbiter.sv
// Shares one synchronous font ROM between N_REQ text requesters: round-robin grant,
// registered ROM address, tagged return. Define FONT_ARB_FIXED_PRIO_EN for fixed priority.
module font_rom_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic                    busy
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DEPTH = ROM_LAT + 1;

  logic [ADDR_W-1:0] w_addr [N_REQ];
  logic              w_found;
  logic [ID_W-1:0]   w_win;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_addr
      assign w_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

`ifdef FONT_ARB_FIXED_PRIO_EN
  // Lowest index wins: scanning downwards leaves the smallest requester last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        w_found = 1'b1;
        w_win   = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0] r_ptr;

  always_comb begin
    logic [ID_W:0] v_sum;
    v_sum   = '0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      v_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (v_sum >= (ID_W+1)'(N_REQ)) begin
        v_sum = v_sum - (ID_W+1)'(N_REQ);
      end
      if (!w_found && req[v_sum[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = v_sum[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
    end
  end
`endif

  always_comb begin
    gnt = '0;
    if (w_found) begin
      gnt[w_win] = 1'b1;
    end
  end

  logic [ADDR_W-1:0] r_rom_addr;
  logic [DEPTH-1:0]  r_tag_vld;
  logic [ID_W-1:0]   r_tag_id [DEPTH];
  logic [N_REQ-1:0]  r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rom_addr   <= '0;
      r_tag_vld[0] <= 1'b0;
      r_tag_id[0]  <= '0;
    end else begin
      if (w_found) begin
        r_rom_addr <= w_addr[w_win];
      end
      r_tag_vld[0] <= w_found;
      r_tag_id[0]  <= w_win;
    end
  end

  // Tag stages track the fetch until rom_data for it is on the bus.
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_tag
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_tag_vld[gi] <= 1'b0;
          r_tag_id[gi]  <= '0;
        end else begin
          r_tag_vld[gi] <= r_tag_vld[gi-1];
          r_tag_id[gi]  <= r_tag_id[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= '0;
      if (r_tag_vld[DEPTH-1]) begin
        r_rvalid[r_tag_id[DEPTH-1]] <= 1'b1;
        r_rdata                     <= rom_data;
      end
    end
  end

  assign rom_addr = r_rom_addr;
  assign rvalid   = r_rvalid;
  assign rdata    = r_rdata;
  assign busy     = |r_tag_vld;

`ifndef SYNTHESIS
  // A pending (requested, not yet granted) address must not move.
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_chk
      a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
        (req[gi] && !gnt[gi]) |=> (!req[gi] || $stable(req_addr[gi*ADDR_W +: ADDR_W])));
    end
  endgenerate
`endif

endmodule
